// File: rtl/anemometer_gate_pkg.sv
// Shared types and constants for the anemometer gate: debounce state
// encoding, BCD digit geometry and the display saturation value.
package anemometer_gate_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } deb_state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int SAT_VALUE  = 9999;

    // Element [0] is the units digit.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd4_t;

    // Binary to 4-digit BCD; only used to build constants.
    function automatic bcd4_t to_bcd4(input int value);
        bcd4_t r;
        int    v;
        v = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[i] = DIGIT_W'(v % 10);
            v    = v / 10;
        end
        return r;
    endfunction

    localparam bcd4_t BCD_SAT = to_bcd4(SAT_VALUE);

    // Decimal increment with ripple carry from the units digit upward.
    function automatic bcd4_t bcd_inc(input bcd4_t v);
        bcd4_t r;
        logic  carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[i] == DIGIT_W'(9)) begin
                    r[i]  = '0;
                    carry = 1'b1;
                end else begin
                    r[i]  = v[i] + DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/anemometer_gate_bcd_counter4.sv
// Four-digit saturating BCD pulse accumulator with a sticky overflow bit.
// digits_next/sat_next show the value including this cycle's inc, so the
// owner can capture a window total that includes a pulse on its last cycle.
module bcd_counter4
    import anemometer_gate_pkg::*;
(
    input  logic  clk,
    input  logic  reset_L,
    input  logic  inc,
    input  logic  clear,
    output bcd4_t digits,
    output logic  sat,
    output bcd4_t digits_next,
    output logic  sat_next
);

    logic at_sat;

    // Next value: increment unless already pinned at 9999; a pulse at 9999 sets sat.
    always_comb begin
        at_sat      = (digits == BCD_SAT);
        digits_next = digits;
        sat_next    = sat;
        if (inc) begin
            if (at_sat) begin
                sat_next = 1'b1;
            end else begin
                digits_next = bcd_inc(digits);
            end
        end
    end

    // Accumulator register; clear wins over inc.
    always_ff @(posedge clk) begin
        if (!reset_L || clear) begin
            digits <= '0;
            sat    <= 1'b0;
        end else begin
            digits <= digits_next;
            sat    <= sat_next;
        end
    end

endmodule

// File: rtl/anemometer_gate.sv
// Anemometer rotation counter: synchronise and debounce the reed contact,
// count accepted rising edges over a fixed gate window, and present the
// last complete window as four BCD digits.
// Strobe semantics: pulse and speed_valid are single-cycle, registered,
// with no back-pressure; digits and overflow are stable whenever
// speed_valid is high and hold until the next window closes.
module anemometer_gate
    import anemometer_gate_pkg::*;
#(
    parameter int GATE_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               rotation,
    output logic               pulse,
    output logic [DIGIT_W-1:0] digit0,
    output logic [DIGIT_W-1:0] digit1,
    output logic [DIGIT_W-1:0] digit2,
    output logic [DIGIT_W-1:0] digit3,
    output logic               speed_valid,
    output logic               overflow,
    output deb_state_t         dbg_state
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          s;
    deb_state_t    state, state_d;
    logic [DW-1:0] dcnt, dcnt_d;
    logic          pulse_d;
    logic [GW-1:0] gcnt;
    logic          gate_end;
    bcd4_t         acc_digits, acc_next, disp_q;
    logic          acc_sat, acc_sat_next;

    // Two-flop synchroniser; s is the only consumer of rotation.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sync_q1 <= 1'b0;
            s       <= 1'b0;
        end else begin
            sync_q1 <= rotation;
            s       <= sync_q1;
        end
    end

    // Debounce state, dwell counter and registered pulse.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= STABLE_LOW;
            dcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_d;
            dcnt  <= dcnt_d;
            pulse <= pulse_d;
        end
    end

    // Debounce next-state: a new level must persist DEBOUNCE_CYCLES samples after the first.
    always_comb begin
        state_d = state;
        dcnt_d  = dcnt;
        pulse_d = 1'b0;
        unique case (state)
            STABLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    dcnt_d  = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                end else if (dcnt == DCNT_LAST) begin
                    state_d = STABLE_HIGH;
                    pulse_d = 1'b1;
                end else begin
                    dcnt_d = dcnt + DW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    dcnt_d  = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                end else if (dcnt == DCNT_LAST) begin
                    state_d = STABLE_LOW;
                end else begin
                    dcnt_d = dcnt + DW'(1);
                end
            end
            default: state_d = STABLE_LOW;
        endcase
    end

    assign dbg_state = state;
    assign gate_end  = (gcnt == GATE_LAST);

    // Free-running gate window counter, restarted by reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            gcnt <= '0;
        end else if (gate_end) begin
            gcnt <= '0;
        end else begin
            gcnt <= gcnt + GW'(1);
        end
    end

    bcd_counter4 u_acc (
        .clk         (clk),
        .reset_L     (reset_L),
        .inc         (pulse),
        .clear       (gate_end),
        .digits      (acc_digits),
        .sat         (acc_sat),
        .digits_next (acc_next),
        .sat_next    (acc_sat_next)
    );

    // Capture the closing window (including a pulse on its last cycle) at gate end.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            disp_q      <= '0;
            overflow    <= 1'b0;
            speed_valid <= 1'b0;
        end else begin
            speed_valid <= gate_end;
            if (gate_end) begin
                disp_q   <= acc_next;
                overflow <= acc_sat_next;
            end
        end
    end

    assign digit0 = disp_q[0];
    assign digit1 = disp_q[1];
    assign digit2 = disp_q[2];
    assign digit3 = disp_q[3];

endmodule
